sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-ported, 1-cycle-latency SRAM between the core's instruction-fetch requester and data-access requester.
- Sits between the mips core's inst/data SRAM-style ports and a unified SRAM (after address translation).
- Issues one access per cycle at most. Gives data requests priority by default. Returns per-port ok pulses and stall signals to the pipeline.

Parameters:
AW, 32, address width of both requesters and the SRAM port
DW, 32, data width; byte-enable width is DW/8

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
inst_req  in  1  instruction fetch request; held with stable inst_addr until inst_ok
inst_addr  in  AW  fetch physical address
inst_rdata  out  DW  fetch data; valid when inst_ok=1, held afterwards
inst_ok  out  1  one-cycle completion pulse for fetch
inst_stall  out  1  inst_req & ~inst_ok
data_req  in  1  data request; held with stable wen/addr/wdata until data_ok
data_wen  in  DW/8  byte write enables; 0 = read
data_addr  in  AW  data physical address
data_wdata  in  DW  store data
data_rdata  out  DW  load data; valid when data_ok=1, held afterwards
data_ok  out  1  one-cycle completion pulse for data
data_stall  out  1  data_req & ~data_ok
sram_en  out  1  SRAM enable for the issue cycle
sram_wen  out  DW/8  SRAM byte write enables
sram_addr  out  AW  SRAM address
sram_wdata  out  DW  SRAM write data
sram_rdata  in  DW  SRAM read data, valid the cycle after issue

Behaviour:
- FSM states: IDLE, I_BUSY (fetch issued last cycle), D_BUSY (data issued last cycle). Reset state is IDLE.
- Eligibility:
  - In IDLE, a port is eligible iff its req=1.
  - In I_BUSY, only data is eligible; the completing fetch request is not re-issued.
  - In D_BUSY, only inst is eligible.
- Grant: combinational from eligibility.
  - Fixed priority is data > inst.
  - On grant: sram_en=1, and sram_addr/wen/wdata are driven from the granted port. An inst grant drives sram_wen=0 and sram_wdata=0.
  - Next state is D_BUSY or I_BUSY accordingly. With no grant, next state is IDLE.
- No grant: sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0.
- Completion:
  - In I_BUSY: inst_ok=1 and inst_rdata=sram_rdata. Same for D_BUSY with data.
  - Writes complete the same way (ok one cycle after issue); data_rdata is then don't-care but is still latched.
- Hold registers:
  - Each port's rdata is latched into a hold register on its completion cycle.
  - Outside completion, rdata outputs the hold register.
- Throughput: back-to-back alternation I,D,I,D gives 1 access/cycle. A single port alone gives one access every 2 cycles.
- Simultaneous requests in IDLE: data granted, inst granted in the following cycle (from D_BUSY).
- A req that deasserts before its ok is a protocol violation. Behaviour is undefined, but the FSM must still return to IDLE.
- Reset (asserted asynchronously, including mid-transaction):
  - State goes to IDLE; inst_ok=data_ok=0; hold registers=0; sram_en=0; sram_wen=0.
  - Stalls follow req.
  - An access in flight is abandoned; no ok is produced after reset release.
- All outputs are 0 during reset except inst_stall/data_stall, which equal the corresponding req.

Optional Feature:
ARB_RR_EN:
- Defined: tie in IDLE (both req=1) goes to the port not granted most recently, tracked by a 1-bit last_grant register. last_grant resets to inst, so the first tie goes to data. last_grant updates on every grant.
- Undefined: fixed data > inst priority and no last_grant register.
- Eligibility rules in BUSY states are identical in both builds.

Test Plan:
- Fetch only, inst_addr=0x00000100, SRAM returns 0x24080001: sram_en=1 in cycle 0; inst_ok=1 with inst_rdata=0x24080001 in cycle 1; next issue in cycle 2; inst_stall=1 in cycle 0 only.
- Store, data_wen=4'b0011, addr=0x00000200, wdata=0xDEADBEEF: sram_wen=4'b0011 and sram_wdata=0xDEADBEEF in cycle 0; data_ok=1 in cycle 1.
- Both req from IDLE, fixed priority: cycle 0 issues data; cycle 1 data_ok and inst issued; cycle 2 inst_ok. Both held continuously gives sustained alternation D,I,D,I, one sram_en per cycle.
- ARB_RR_EN build: two ties separated by IDLE give first grant data, second grant inst.
- Load issued, rst asserted mid-D_BUSY for 1 cycle: data_ok stays 0; data_rdata=0 after reset; state IDLE; re-issue after release completes normally.
- Hold check: load returns 0x12345678 with data_ok; sram_rdata then changes to 0xFFFFFFFF on an inst access; data_rdata remains 0x12345678.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 1-cycle-latency SRAM between fetch and data requesters.
// Optional ARB_RR_EN: round-robin tie-break in IDLE instead of fixed data > inst priority.
module sram_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    output logic            inst_ok,
    output logic            inst_stall,
    input  logic            data_req,
    input  logic [DW/8-1:0] data_wen,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    output logic            data_ok,
    output logic            data_stall,
    output logic            sram_en,
    output logic [DW/8-1:0] sram_wen,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_wdata,
    input  logic [DW-1:0]   sram_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] inst_hold_q, inst_hold_d, data_hold_q, data_hold_d;
    logic          inst_elig, data_elig, gnt_i, gnt_d;
`ifdef ARB_RR_EN
    logic          last_q, last_d;
`endif

    // Eligibility is gated by rst so nothing is issued while reset is held.
    always_comb begin
        inst_elig   = inst_req & ~rst & (state_q != I_BUSY);
        data_elig   = data_req & ~rst & (state_q != D_BUSY);
`ifdef ARB_RR_EN
        gnt_d       = data_elig & (~inst_elig | ~last_q);
`else
        gnt_d       = data_elig;
`endif
        gnt_i       = inst_elig & ~gnt_d;
`ifdef ARB_RR_EN
        last_d      = gnt_d ? 1'b1 : gnt_i ? 1'b0 : last_q;
`endif
        state_d     = gnt_d ? D_BUSY : gnt_i ? I_BUSY : IDLE;
        inst_ok     = state_q == I_BUSY;
        data_ok     = state_q == D_BUSY;
        inst_rdata  = inst_ok ? sram_rdata : inst_hold_q;
        data_rdata  = data_ok ? sram_rdata : data_hold_q;
        inst_hold_d = inst_rdata;
        data_hold_d = data_rdata;
        inst_stall  = inst_req & ~inst_ok;
        data_stall  = data_req & ~data_ok;
        sram_en     = gnt_d | gnt_i;
        sram_addr   = gnt_d ? data_addr : gnt_i ? inst_addr : '0;
        sram_wen    = gnt_d ? data_wen : '0;
        sram_wdata  = gnt_d ? data_wdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            inst_hold_q <= '0;
            data_hold_q <= '0;
`ifdef ARB_RR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            inst_hold_q <= inst_hold_d;
            data_hold_q <= data_hold_d;
`ifdef ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of grant order, completion, hold registers and reset.
module tb_sram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, inst_ok, data_ok, inst_stall, data_stall, sram_en;
    logic [31:0] inst_addr, data_addr, data_wdata, inst_rdata, data_rdata;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic [3:0]  data_wen, sram_wen;
    int          n_checks = 0;
    int          n_err = 0;

    sram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_ok(inst_ok), .inst_stall(inst_stall),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
        .data_stall(data_stall),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b1; data_req = 1'b0; inst_addr = 32'h100;
        data_addr = '0; data_wdata = '0; data_wen = '0; sram_rdata = 32'h5555_AAAA;
        #2;
        check("rst_sram_en", sram_en, 0);
        check("rst_inst_stall", inst_stall, 1);
        check("rst_inst_ok", inst_ok, 0);
        check("rst_inst_rdata", inst_rdata, 0);
        check("rst_data_rdata", data_rdata, 0);

        // Fetch only
        tick(); rst = 1'b0; settle();
        check("f0_en", sram_en, 1);
        check("f0_addr", sram_addr, 32'h100);
        check("f0_wen", sram_wen, 0);
        check("f0_stall", inst_stall, 1);
        tick(); sram_rdata = 32'h2408_0001; settle();
        check("f1_ok", inst_ok, 1);
        check("f1_rdata", inst_rdata, 32'h2408_0001);
        check("f1_stall", inst_stall, 0);
        check("f1_en", sram_en, 0);
        tick(); inst_addr = 32'h104; sram_rdata = 32'h0; settle();
        check("f2_en", sram_en, 1);
        check("f2_addr", sram_addr, 32'h104);
        check("f2_ok", inst_ok, 0);
        check("f2_hold", inst_rdata, 32'h2408_0001);
        tick(); sram_rdata = 32'h1111_2222; settle();
        check("f3_rdata", inst_rdata, 32'h1111_2222);
        inst_req = 1'b0;
        tick(); sram_rdata = 32'h0; settle();
        check("f4_idle_en", sram_en, 0);
        check("f4_hold", inst_rdata, 32'h1111_2222);

        // Store
        data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h200; data_wdata = 32'hDEAD_BEEF; settle();
        check("s0_en", sram_en, 1);
        check("s0_wen", sram_wen, 4'b0011);
        check("s0_wdata", sram_wdata, 32'hDEAD_BEEF);
        check("s0_addr", sram_addr, 32'h200);
        check("s0_stall", data_stall, 1);
        tick(); settle();
        check("s1_ok", data_ok, 1);
        check("s1_stall", data_stall, 0);
        data_req = 1'b0;
        tick(); settle();
        check("s2_ok", data_ok, 0);

        // Both requesting from IDLE: data first, then alternation
        do_reset();
        inst_req = 1'b1; inst_addr = 32'h300;
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h400; data_wdata = 32'hAAAA_5555; settle();
        check("b0_addr", sram_addr, 32'h400);
        check("b0_wen", sram_wen, 0);
        check("b0_istall", inst_stall, 1);
        tick(); sram_rdata = 32'h1234_5678; settle();
        check("b1_dok", data_ok, 1);
        check("b1_drdata", data_rdata, 32'h1234_5678);
        check("b1_en", sram_en, 1);
        check("b1_addr", sram_addr, 32'h300);
        check("b1_wdata", sram_wdata, 0);
        tick(); sram_rdata = 32'hFFFF_FFFF; settle();
        check("b2_iok", inst_ok, 1);
        check("b2_irdata", inst_rdata, 32'hFFFF_FFFF);
        check("b2_dhold", data_rdata, 32'h1234_5678);
        check("b2_addr", sram_addr, 32'h400);
        check("b2_en", sram_en, 1);
        tick(); settle();
        check("b3_dok", data_ok, 1);
        check("b3_addr", sram_addr, 32'h300);
        inst_req = 1'b0; data_req = 1'b0;
        tick(); tick(); settle();
        check("b5_idle", {inst_ok, data_ok, sram_en}, 0);

        // Two ties separated by IDLE
        do_reset();
        inst_req = 1'b1; inst_addr = 32'h700; data_req = 1'b1; data_addr = 32'h600; settle();
        check("t0_addr", sram_addr, 32'h600);
        tick(); settle();
        check("t1_addr", sram_addr, 32'h700);
        tick(); inst_req = 1'b0; settle();
        check("t2_iok", inst_ok, 1);
        check("t2_addr", sram_addr, 32'h600);
        tick(); data_req = 1'b0; settle();
        check("t3_dok", data_ok, 1);
        check("t3_en", sram_en, 0);
        tick(); settle();
        check("t4_en", sram_en, 0);
        tick(); inst_req = 1'b1; data_req = 1'b1; settle();
`ifdef ARB_RR_EN
        check("t5_addr", sram_addr, 32'h700);
`else
        check("t5_addr", sram_addr, 32'h600);
`endif
        inst_req = 1'b0; data_req = 1'b0;
        do_reset();

        // Reset mid-D_BUSY abandons the load
        data_req = 1'b1; data_wen = 4'b0; data_addr = 32'h500; settle();
        check("r0_en", sram_en, 1);
        tick(); rst = 1'b1; sram_rdata = 32'h9999_9999; settle();
        check("r1_dok", data_ok, 0);
        check("r1_drdata", data_rdata, 0);
        check("r1_en", sram_en, 0);
        check("r1_dstall", data_stall, 1);
        tick(); rst = 1'b0; settle();
        check("r2_dok", data_ok, 0);
        check("r2_en", sram_en, 1);
        check("r2_addr", sram_addr, 32'h500);
        tick(); sram_rdata = 32'hCAFE_F00D; settle();
        check("r3_dok", data_ok, 1);
        check("r3_drdata", data_rdata, 32'hCAFE_F00D);
        data_req = 1'b0;
        tick(); sram_rdata = 32'h0; settle();
        check("r4_hold", data_rdata, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
